// File: rtl/avmm_copy_pkg.sv
// Shared types and limits for the Avalon-MM word copy master.
// Holds the copy FSM state encoding and the supported read-latency bound.
package avmm_copy_pkg;

  localparam int MAX_READ_LATENCY = 4;
  localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/avmm_copy_if.sv
// Avalon-MM master bus bundle (word addressed, fixed read latency, waitrequest).
interface avmm_copy_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   m_address;
  logic                m_read;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_waitrequest;

  modport master (
    output m_address, m_read, m_write, m_byteenable, m_writedata,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    input  m_address, m_read, m_write, m_byteenable, m_writedata,
    output m_readdata, m_waitrequest
  );

endinterface

// File: rtl/avmm_copy_master.sv
// Copies LENGTH words from src_addr to dst_addr over one Avalon-MM master port.
// Optional running sum of written words: define AVMM_COPY_CHECKSUM_EN.
module avmm_copy_master
  import avmm_copy_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [LEN_W-1:0]   length,
  output logic               busy,
  output logic               done,
`ifdef AVMM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0]  checksum,
`endif
  avmm_copy_if.master        m
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("avmm_copy_master: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LATENCY - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic [LAT_CNT_W-1:0] lat_q;

  logic start_ok, rd_acc, wr_acc, lat_done;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign rd_acc   = (state_q == ST_RD_REQ) && !m.m_waitrequest;
  assign wr_acc   = (state_q == ST_WR_REQ) && !m.m_waitrequest;
  assign lat_done = (lat_q == LAT_LAST);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Strobes decode straight from state so an async reset drops them at once.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    done        = 1'b0;
    m.m_read    = 1'b0;
    m.m_write   = 1'b0;
    m.m_address = src_q;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (length == '0) ? ST_FINISH : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        m.m_read = 1'b1;
        if (!m.m_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_done) state_d = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        m.m_write   = 1'b1;
        m.m_address = dst_q;
        if (!m.m_waitrequest) state_d = (cnt_q == LEN_W'(1)) ? ST_FINISH : ST_RD_REQ;
      end
      ST_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m.m_writedata  = data_q;
  assign m.m_byteenable = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      lat_q  <= '0;
    end else begin
      if (start_ok) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        cnt_q <= length;
      end
      // Latency counter restarts on each accepted read; data lands on its last tick.
      if (rd_acc) lat_q <= '0;
      else if (state_q == ST_RD_WAIT) lat_q <= lat_q + LAT_CNT_W'(1);
      if (state_q == ST_RD_WAIT && lat_done) data_q <= m.m_readdata;
      if (wr_acc) begin
        src_q <= src_q + ADDR_W'(1);
        dst_q <= dst_q + ADDR_W'(1);
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

`ifdef AVMM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (wr_acc)   checksum <= checksum + data_q;
  end
`endif

endmodule

// File: tb/tb_avmm_copy_master.sv
// Self-checking bench for avmm_copy_master: random-memory slave with fixed read
// latency, random waitrequest, and a word-level copy model of expected memory.
module tb_avmm_copy_master;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 32;
  localparam int LEN_W        = 13;
  localparam int READ_LATENCY = 1;
  localparam int MEM_WORDS    = 1 << ADDR_W;
  localparam int MASK         = MEM_WORDS - 1;
  localparam int TIMEOUT      = 2000;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [LEN_W-1:0]  length;
  logic              busy, done;
`ifdef AVMM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int vectors;
  int miscompares;

  avmm_copy_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avmm_copy_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
`ifdef AVMM_COPY_CHECKSUM_EN
    .checksum (checksum),
`endif
    .m        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [DATA_W-1:0] mem     [MEM_WORDS];
  logic [DATA_W-1:0] exp_mem [MEM_WORDS];
  logic [DATA_W-1:0] pipe_d  [READ_LATENCY];
  bit                pipe_v  [READ_LATENCY];
  int                rd_acc_cnt, wr_acc_cnt, rd_cycles, wr_cycles;
  int                rd_log[$];
  bit                rand_wait;

  initial begin
    rd_acc_cnt = 0; wr_acc_cnt = 0; rd_cycles = 0; wr_cycles = 0;
  end

  always @(posedge clk) begin
    bit acc;
    acc = bus.m_read && !bus.m_waitrequest;
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      pipe_d[i] = pipe_d[i-1];
      pipe_v[i] = pipe_v[i-1];
    end
    pipe_d[0] = mem[int'(bus.m_address)];
    pipe_v[0] = acc;
    if (acc) begin
      rd_acc_cnt++;
      rd_log.push_back(int'(bus.m_address));
    end
    if (bus.m_write && !bus.m_waitrequest) begin
      wr_acc_cnt++;
      mem[int'(bus.m_address)] = bus.m_writedata;
    end
    // Outside the valid slot readdata carries junk so mistimed capture shows.
    bus.m_readdata <= pipe_v[READ_LATENCY-1] ? pipe_d[READ_LATENCY-1] : $urandom;
  end

  always @(posedge clk) begin
    #1;
    bus.m_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  // Command stability under stall and strobe exclusivity, checked mid-cycle.
  bit                hold_prev;
  logic              prev_rd, prev_wr;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_wdata;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.m_read || bus.m_write) begin
        vectors++;
        if ((bus.m_read && bus.m_write) !== 1'b0) begin
          miscompares++;
          $display("FAIL strobe_exclusive: read=%b write=%b required not both", bus.m_read, bus.m_write);
        end
      end
      if (hold_prev) begin
        vectors++;
        if (bus.m_read !== prev_rd || bus.m_write !== prev_wr ||
            bus.m_address !== prev_addr || (prev_wr && bus.m_writedata !== prev_wdata)) begin
          miscompares++;
          $display("FAIL stall_stable: rd=%b wr=%b addr=%h data=%h required rd=%b wr=%b addr=%h data=%h",
                   bus.m_read, bus.m_write, bus.m_address, bus.m_writedata,
                   prev_rd, prev_wr, prev_addr, prev_wdata);
        end
      end
      if (bus.m_read)  rd_cycles++;
      if (bus.m_write) wr_cycles++;
      hold_prev  = (bus.m_read || bus.m_write) && bus.m_waitrequest;
      prev_rd    = bus.m_read;
      prev_wr    = bus.m_write;
      prev_addr  = bus.m_address;
      prev_wdata = bus.m_writedata;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- reference model helpers ----------------
  task automatic fill_mem();
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = $urandom;
      exp_mem[i] = mem[i];
    end
  endtask

  // Word-by-word copy on the expected image; returns the sum of words moved.
  task automatic model_copy(input int s, input int d, input int n, output logic [DATA_W-1:0] sum);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      exp_mem[(d + i) & MASK] = exp_mem[(s + i) & MASK];
      sum += exp_mem[(s + i) & MASK];
    end
  endtask

  task automatic check_mem(input string tag);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < MEM_WORDS; i++)
      if (mem[i] !== exp_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s mem_image: %0d words differ, first @%h got %h required %h",
               tag, bad, first, mem[first], exp_mem[first]);
    end
  endtask

  task automatic start_copy(input int s, input int d, input int n);
    @(negedge clk);
    src_addr = ADDR_W'(s);
    dst_addr = ADDR_W'(d);
    length   = LEN_W'(n);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Waits for done (counting edges after the start-sampling edge), checks busy
  // throughout, busy low with done, and a single-cycle done pulse.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s busy_during_copy: busy=%b required 1 at cycle %0d", tag, busy, cycles);
      end
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, TIMEOUT);
    end else begin
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s busy_at_done: busy=%b required 0", tag, busy);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s done_width: done=%b required 0 one cycle later", tag, done);
      end
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", tag, got, want);
    end
  endtask

  task automatic copy_and_check(input string tag, input int s, input int d, input int n);
    int cyc, r0, w0;
    logic [DATA_W-1:0] sum;
    r0 = rd_acc_cnt; w0 = wr_acc_cnt;
    model_copy(s, d, n, sum);
    start_copy(s, d, n);
    wait_done(tag, cyc);
    check_mem(tag);
    check_int({tag, " reads_accepted"}, rd_acc_cnt - r0, n);
    check_int({tag, " writes_accepted"}, wr_acc_cnt - w0, n);
    if (!rand_wait && n > 0) check_int({tag, " cycles_to_done"}, cyc, n * (2 + READ_LATENCY));
`ifdef AVMM_COPY_CHECKSUM_EN
    vectors++;
    if (checksum !== sum) begin
      miscompares++;
      $display("FAIL %s checksum: got %h required %h", tag, checksum, sum);
    end
`else
    if (sum === 'x) $display("unexpected X sum");
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, bus.m_read, bus.m_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: busy/done/rd/wr=%b required 0000",
               {busy, done, bus.m_read, bus.m_write});
    end
`ifdef AVMM_COPY_CHECKSUM_EN
    vectors++;
    if (checksum !== '0) begin
      miscompares++;
      $display("FAIL reset_checksum: got %h required 0", checksum);
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_mem();
    copy_and_check("basic", 'h010, 'h100, 4);
  endtask

  task automatic test_zero_len();
    int cyc, rc, wc;
    fill_mem();
    rc = rd_cycles; wc = wr_cycles;
    start_copy('h020, 'h200, 0);
    wait_done("zero_len", cyc);
    vectors++;
    if (cyc > 2) begin
      miscompares++;
      $display("FAIL zero_len latency: done after %0d cycles required <= 2", cyc);
    end
    check_int("zero_len read_cycles", rd_cycles - rc, 0);
    check_int("zero_len write_cycles", wr_cycles - wc, 0);
    check_mem("zero_len");
  endtask

  task automatic test_random_wait();
    rand_wait = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int s, n;
      fill_mem();
      s = int'($urandom_range(0, MASK));
      n = (k == 0) ? 8 : int'($urandom_range(1, 16));
      copy_and_check("random_wait", s, (s + 'h800) & MASK, n);
    end
    rand_wait = 1'b0;
  endtask

  task automatic test_wrap();
    fill_mem();
    rd_log.delete();
    copy_and_check("wrap", 'h1FFE, 'h0400, 4);
    check_int("wrap read_count", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      check_int("wrap read_addr", rd_log[i], ('h1FFE + i) & MASK);
  endtask

  task automatic test_reset_mid();
    int guard, w0;
    bit saw_done;
    fill_mem();
    w0 = wr_acc_cnt;
    start_copy('h0300, 'h0600, 4);
    guard = 0;
    while (!(bus.m_write === 1'b1 && wr_acc_cnt == w0 + 1) && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    check_int("reset_mid reached_word2_write", int'(bus.m_write === 1'b1 && wr_acc_cnt == w0 + 1), 1);
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, bus.m_read, bus.m_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid immediate: busy/done/rd/wr=%b required 0000",
               {busy, done, bus.m_read, bus.m_write});
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    check_int("reset_mid no_done_or_busy", int'(saw_done), 0);
    check_int("reset_mid writes_before_abort", wr_acc_cnt - w0, 1);
    fill_mem();
    copy_and_check("after_reset", 'h0700, 'h0A00, 5);
  endtask

  task automatic test_start_ignored();
    int cyc, r0;
    logic [DATA_W-1:0] sum;
    fill_mem();
    r0 = rd_acc_cnt;
    model_copy('h0040, 'h0900, 6, sum);
    start_copy('h0040, 'h0900, 6);
    @(negedge clk);
    src_addr = ADDR_W'('h1000); dst_addr = ADDR_W'('h1100); length = LEN_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_ignored", cyc);
    repeat (3) @(negedge clk);
    check_int("start_ignored busy_after", int'(busy), 0);
    check_int("start_ignored reads", rd_acc_cnt - r0, 6);
    check_mem("start_ignored");
  endtask

`ifdef AVMM_COPY_CHECKSUM_EN
  task automatic test_checksum();
    int cyc;
    fill_mem();
    mem['h50] = 32'd1; mem['h51] = 32'd2; mem['h52] = 32'd3; mem['h53] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) exp_mem['h50 + i] = mem['h50 + i];
    for (int i = 0; i < 4; i++) exp_mem['h150 + i] = mem['h50 + i];
    start_copy('h50, 'h150, 4);
    wait_done("checksum", cyc);
    vectors++;
    if (checksum !== 32'h0000_0005) begin
      miscompares++;
      $display("FAIL checksum_fixed: got %h required 00000005", checksum);
    end
    check_mem("checksum");
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    rand_wait = 1'b0; hold_prev = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_random_wait();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
`ifdef AVMM_COPY_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
